im_refill_ctrl: RTL

Sequencing controller for the 8-way instruction-cache set array: accepts CPU fetch requests, drives lookup, and on a miss fetches a 512-bit line from memory and writes it into a victim way. Also runs a full invalidate sweep on request. Sits between the fetch stage, the set array (select/set/memWrite/lineSelect/tag/valid/line inputs, cacheHit/outWord outputs) and the memory read port.

---
 rtl/im_cache_pkg.sv | 33 +++
 rtl/im_victim_sel.sv | 47 ++++
 rtl/im_refill_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/im_cache_pkg.sv
// Shared constants, FSM state type and address slicing for the I-cache refill controller.
// Address layout: {tag[31:7], index[6], offset[5:0]}.
package im_cache_pkg;

    localparam int TAG_W  = 25;
    localparam int IDX_W  = 1;
    localparam int OFF_W  = 6;
    localparam int LINE_W = 512;
    localparam int WAYS   = 8;
    localparam int WAY_W  = 3;
    localparam int SETS   = 1 << IDX_W;
    localparam int ADDR_W = 32;

    localparam int IDX_LSB = OFF_W;
    localparam int TAG_LSB = OFF_W + IDX_W;
    localparam int FLUSH_W = IDX_W + WAY_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        FILL,
        FLUSH
    } refillState_t;

    function automatic logic [WAYS-1:0] wayOneHot(input logic [WAY_W-1:0] way);
        logic [WAYS-1:0] oneHot;
        oneHot      = '0;
        oneHot[way] = 1'b1;
        return oneHot;
    endfunction

endpackage

// File: rtl/im_victim_sel.sv
// Victim way selection: lowest invalid way per set, else per-set round-robin pointer.
// Latency: victim is combinational from lookupSet; state updates on the fill/flush strobe edge.
// Backpressure: none, strobes are always accepted.
module im_victim_sel
    import im_cache_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] lookupSet,
    input  logic             fillEn,
    input  logic             flushEn,
    output logic [WAYS-1:0]  victimOneHot
);

    logic [SETS-1:0][WAYS-1:0]  shadowValid;
    logic [SETS-1:0][WAY_W-1:0] rrPtr;
    logic [WAY_W-1:0]           victimIdx;
    logic                       allValid;

    // Walk from the top so the lowest invalid way wins.
    always_comb begin
        allValid  = &shadowValid[lookupSet];
        victimIdx = rrPtr[lookupSet];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!shadowValid[lookupSet][w]) begin
                victimIdx = WAY_W'(w);
            end
        end
        victimOneHot = wayOneHot(victimIdx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadowValid <= '0;
            rrPtr       <= '0;
        end else if (flushEn) begin
            shadowValid <= '0;
            rrPtr       <= '0;
        end else if (fillEn) begin
            shadowValid[lookupSet][victimIdx] <= 1'b1;
            if (allValid) begin
                rrPtr[lookupSet] <= rrPtr[lookupSet] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/im_refill_ctrl.sv
// I-cache lookup/refill/flush sequencer; define IM_PERF_CNT_EN to add hit/miss counters.
// Latency: hit 1 cycle after acceptance; miss 1 + memory latency + 2; flush 16 cycles.
// Backpressure: cpu_ready low outside IDLE; mem_req held until mem_rvalid.
module im_refill_ctrl
    import im_cache_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic                cpu_ready,
    output logic                rsp_valid,
    input  logic                flush_req,
    output logic                flush_done,
    output logic                arr_select,
    output logic [IDX_W-1:0]    arr_set,
    output logic [TAG_W-1:0]    arr_tag,
    output logic [OFF_W-1:0]    arr_offset,
    output logic                arr_valid,
    output logic                arr_write,
    output logic [WAYS-1:0]     arr_line_sel,
    output logic [LINE_W-1:0]   arr_line,
    input  logic                arr_hit,
    output logic                mem_req,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    input  logic                mem_rvalid,
`ifdef IM_PERF_CNT_EN
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_misses,
`endif
    input  logic [LINE_W-1:0]   mem_rdata
);

    refillState_t        state, stateNext;
    logic [ADDR_W-1:0]   addrQ;
    logic [LINE_W-1:0]   fillBuf;
    logic                replayQ;
    logic                errSticky;
    logic [FLUSH_W-1:0]  flushCnt;

    logic                acceptReq, captureLine, fillEn, flushEn, replayMiss;
    logic [WAYS-1:0]     victimOneHot;

    logic [TAG_W-1:0]    tagQ;
    logic [IDX_W-1:0]    idxQ;
    logic [OFF_W-1:0]    offQ;

    assign tagQ = addrQ[ADDR_W-1:TAG_LSB];
    assign idxQ = addrQ[TAG_LSB-1:IDX_LSB];
    assign offQ = addrQ[OFF_W-1:0];

    im_victim_sel uVictim (
        .clk          (clk),
        .reset        (reset),
        .lookupSet    (idxQ),
        .fillEn       (fillEn),
        .flushEn      (flushEn),
        .victimOneHot (victimOneHot)
    );

    always_comb begin
        stateNext    = state;
        cpu_ready    = 1'b0;
        rsp_valid    = 1'b0;
        flush_done   = 1'b0;
        arr_select   = 1'b0;
        arr_set      = '0;
        arr_tag      = '0;
        arr_offset   = '0;
        arr_valid    = 1'b0;
        arr_write    = 1'b0;
        arr_line_sel = '0;
        arr_line     = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        acceptReq    = 1'b0;
        captureLine  = 1'b0;
        fillEn       = 1'b0;
        flushEn      = 1'b0;
        replayMiss   = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (flush_req) begin
                    stateNext = FLUSH;
                end else if (cpu_req) begin
                    acceptReq = 1'b1;
                    stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                arr_select = 1'b1;
                arr_set    = idxQ;
                arr_tag    = tagQ;
                arr_offset = offQ;
                if (arr_hit) begin
                    rsp_valid = 1'b1;
                    stateNext = IDLE;
                end else if (replayQ) begin
                    // A just-filled line that still misses: give up rather than loop.
                    replayMiss = 1'b1;
                    stateNext  = IDLE;
                end else begin
                    stateNext = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {tagQ, idxQ};
                if (mem_rvalid) begin
                    captureLine = 1'b1;
                    stateNext   = FILL;
                end
            end
            FILL: begin
                arr_write    = 1'b1;
                arr_line_sel = victimOneHot;
                arr_tag      = tagQ;
                arr_valid    = 1'b1;
                arr_line     = fillBuf;
                arr_set      = idxQ;
                fillEn       = 1'b1;
                stateNext    = LOOKUP;
            end
            FLUSH: begin
                arr_write    = 1'b1;
                arr_set      = flushCnt[WAY_W +: IDX_W];
                arr_line_sel = wayOneHot(flushCnt[WAY_W-1:0]);
                if (&flushCnt) begin
                    flushEn    = 1'b1;
                    flush_done = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addrQ     <= '0;
            replayQ   <= 1'b0;
            errSticky <= 1'b0;
            flushCnt  <= '0;
        end else begin
            state     <= stateNext;
            errSticky <= errSticky | replayMiss;
            if (acceptReq) begin
                addrQ   <= cpu_addr;
                replayQ <= 1'b0;
            end else if (fillEn) begin
                replayQ <= 1'b1;
            end
            flushCnt <= (state == FLUSH) ? flushCnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (captureLine) begin
            fillBuf <= mem_rdata;
        end
    end

`ifdef IM_PERF_CNT_EN
    logic firstLookup;
    assign firstLookup = (state == LOOKUP) && !replayQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (flushEn) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (firstLookup) begin
            if (arr_hit && !(&perf_hits)) begin
                perf_hits <= perf_hits + 1'b1;
            end
            if (!arr_hit && !(&perf_misses)) begin
                perf_misses <= perf_misses + 1'b1;
            end
        end
    end
`endif

endmodule
